// File: rtl/db9md_pad_responder_if.sv
// DB9 Mega Drive link between a joy_db9md reader (master) and the pad-side responder (slave).
interface db9md_pad_responder_if;
   logic       joy_mdsel;
   logic       joy_split;
   logic [5:0] joy_out;
   logic [1:0] phase;

   modport master (
      output joy_mdsel,
      output joy_split,
      input  joy_out,
      input  phase
   );

   modport slave (
      input  joy_mdsel,
      input  joy_split,
      output joy_out,
      output phase
   );
endinterface

// File: rtl/db9md_pad_responder.sv
// Pad-side DB9 Mega Drive responder: drives active-low pad lines for two pads following the
// reader's select strobes, including the 6-button select-phase sequence with idle timeout.
module db9md_pad_responder #(
   parameter bit          SIX_BTN = 1'b1,
   parameter int unsigned TIMEOUT = 72000
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [11:0]                  pad1,
   input  logic [11:0]                  pad2,
   db9md_pad_responder_if.slave         bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic                sel_meta, sel_s, sel_d;
   logic                split_meta, split_s;
   logic [1:0]          n_q, n_d, n_base;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [5:0]          out_q, out_d;
   logic [11:0]         p;
   logic                sel_edge, sel_rise, timeout_hit;

   always_comb begin
      sel_edge    = sel_s ^ sel_d;
      sel_rise    = sel_s & ~sel_d;
      timeout_hit = (cnt_q == CntW'(TIMEOUT));

      // An edge coinciding with the timeout is counted from phase 0.
      n_base = timeout_hit ? 2'd0 : n_q;
      n_d    = sel_rise ? n_base + 2'd1 : n_base;

      if (sel_edge) begin
         cnt_d = '0;
      end else if (timeout_hit) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Output is {pin9, pin6, pin4, pin3, pin2, pin1}, all active-low.
   always_comb begin
      p = split_s ? pad1 : pad2;
      if (sel_s) begin
         if (SIX_BTN && n_d == 2'd3) begin
            out_d = {~p[6], ~p[5], ~p[11], ~p[10], ~p[9], ~p[8]};
         end else begin
            out_d = {~p[6], ~p[5], ~p[0], ~p[1], ~p[2], ~p[3]};
         end
      end else begin
         if (SIX_BTN && n_d == 2'd2) begin
            out_d = {~p[7], ~p[4], 4'b0000};
         end else if (SIX_BTN && n_d == 2'd3) begin
            out_d = {~p[7], ~p[4], 4'b1111};
         end else begin
            out_d = {~p[7], ~p[4], 2'b00, ~p[2], ~p[3]};
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sel_meta   <= 1'b1;
         sel_s      <= 1'b1;
         sel_d      <= 1'b1;
         split_meta <= 1'b1;
         split_s    <= 1'b1;
         n_q        <= 2'd0;
         cnt_q      <= '0;
         out_q      <= 6'h3F;
      end else begin
         sel_meta   <= bus.joy_mdsel;
         sel_s      <= sel_meta;
         sel_d      <= sel_s;
         split_meta <= bus.joy_split;
         split_s    <= split_meta;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
      end
   end

   assign bus.joy_out = out_q;
   assign bus.phase   = n_q;

endmodule

// File: tb/tb_db9md_pad_responder.sv
// Directed bench for db9md_pad_responder: a 6-button and a 3-button instance share stimulus.
module tb_db9md_pad_responder;

   localparam int unsigned TimeoutTb = 64;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b0;
   logic [11:0] pad1    = '0;
   logic [11:0] pad2    = '0;
   logic        mdsel   = 1'b1;
   logic        split   = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;

   db9md_pad_responder_if bus6 ();
   db9md_pad_responder_if bus3 ();

   assign bus6.joy_mdsel = mdsel;
   assign bus6.joy_split = split;
   assign bus3.joy_mdsel = mdsel;
   assign bus3.joy_split = split;

   db9md_pad_responder #(.SIX_BTN(1'b1), .TIMEOUT(TimeoutTb)) dut6 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .pad1    (pad1),
      .pad2    (pad2),
      .bus     (bus6)
   );

   db9md_pad_responder #(.SIX_BTN(1'b0), .TIMEOUT(TimeoutTb)) dut3 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .pad1    (pad1),
      .pad2    (pad2),
      .bus     (bus3)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int k);
      repeat (k) @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_reset();
      mdsel = 1'b1;
      split = 1'b1;
      pad1  = 12'h009;
      pad2  = 12'h000;
      reset = 1'b1;
      #2;
      tests_run++;
      if (bus6.joy_out !== 6'h3F) begin
         tests_failed++;
         $display("FAIL reset_out6: got %b expected %b", bus6.joy_out, 6'h3F);
      end
      tests_run++;
      if (bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_phase6: got %0d expected 0", bus6.phase);
      end
      tick(2);
      reset = 1'b0;
      tick(4);
      tests_run++;
      if (bus6.joy_out !== 6'b110110) begin
         tests_failed++;
         $display("FAIL reset_idle_out6: got %b expected %b", bus6.joy_out, 6'b110110);
      end
      tests_run++;
      if (bus3.joy_out !== 6'b110110) begin
         tests_failed++;
         $display("FAIL reset_idle_out3: got %b expected %b", bus3.joy_out, 6'b110110);
      end
      tests_run++;
      if (bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_idle_phase6: got %0d expected 0", bus6.phase);
      end
   endtask

   task automatic test_six_btn();
      logic [1:0]  ph_tab  [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      logic [5:0]  exp_fff [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0F, 6'h00};
      logic [5:0]  exp_mix [8] = '{6'b010001, 6'b101001, 6'b010001, 6'b101001,
                                   6'b010000, 6'b101010, 6'b011111, 6'b101001};
      logic [11:0] pads    [2] = '{12'hFFF, 12'h5A6};
      logic [5:0]  expv;
      for (int pi = 0; pi < 2; pi++) begin
         pad1  = pads[pi];
         split = 1'b1;
         mdsel = 1'b1;
         do_reset();
         for (int k = 0; k < 8; k++) begin
            mdsel = ~mdsel;
            tick(3);
            expv = (pi == 0) ? exp_fff[k] : exp_mix[k];
            tests_run++;
            if (bus6.joy_out !== expv || bus6.phase !== ph_tab[k]) begin
               tests_failed++;
               $display("FAIL six_btn pad=%h step=%0d: got out=%b phase=%0d expected out=%b phase=%0d",
                        pads[pi], k, bus6.joy_out, bus6.phase, expv, ph_tab[k]);
            end
         end
      end
   endtask

   task automatic test_three_btn();
      logic [1:0]  ph_tab  [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      logic [11:0] pads    [2] = '{12'hFFF, 12'h5A6};
      logic [5:0]  expv;
      for (int pi = 0; pi < 2; pi++) begin
         pad1  = pads[pi];
         split = 1'b1;
         mdsel = 1'b1;
         do_reset();
         for (int k = 0; k < 8; k++) begin
            mdsel = ~mdsel;
            tick(3);
            if (pi == 0) expv = 6'h00;
            else         expv = mdsel ? 6'b101001 : 6'b010001;
            tests_run++;
            if (bus3.joy_out !== expv || bus3.phase !== ph_tab[k]) begin
               tests_failed++;
               $display("FAIL three_btn pad=%h step=%0d: got out=%b phase=%0d expected out=%b phase=%0d",
                        pads[pi], k, bus3.joy_out, bus3.phase, expv, ph_tab[k]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      pad1  = 12'h5A6;
      split = 1'b1;
      mdsel = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         mdsel = ~mdsel;
         tick(3);
      end
      tests_run++;
      if (bus6.phase !== 2'd2) begin
         tests_failed++;
         $display("FAIL timeout_pre: got phase=%0d expected 2", bus6.phase);
      end
      tick(TimeoutTb + 8);
      tests_run++;
      if (bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL timeout_idle: got phase=%0d expected 0", bus6.phase);
      end
      mdsel = 1'b0;
      tick(3);
      mdsel = 1'b1;
      tick(3);
      tests_run++;
      if (bus6.phase !== 2'd1 || bus6.joy_out !== 6'b101001) begin
         tests_failed++;
         $display("FAIL timeout_rise: got phase=%0d out=%b expected phase=1 out=%b",
                  bus6.phase, bus6.joy_out, 6'b101001);
      end
      // Edges spaced below the timeout keep the phase alive.
      tick(TimeoutTb - 10);
      mdsel = 1'b0;
      tick(TimeoutTb - 10);
      tests_run++;
      if (bus6.phase !== 2'd1 || bus6.joy_out !== 6'b010001) begin
         tests_failed++;
         $display("FAIL timeout_restart: got phase=%0d out=%b expected phase=1 out=%b",
                  bus6.phase, bus6.joy_out, 6'b010001);
      end
   endtask

   task automatic test_split();
      pad1  = 12'h000;
      pad2  = 12'h010;
      split = 1'b1;
      mdsel = 1'b1;
      do_reset();
      mdsel = 1'b0;
      tick(3);
      tests_run++;
      if (bus6.joy_out !== 6'b110011 || bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL split_pad1: got out=%b phase=%0d expected out=%b phase=0",
                  bus6.joy_out, bus6.phase, 6'b110011);
      end
      split = 1'b0;
      tick(3);
      tests_run++;
      if (bus6.joy_out !== 6'b100011 || bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL split_pad2: got out=%b phase=%0d expected out=%b phase=0",
                  bus6.joy_out, bus6.phase, 6'b100011);
      end
      tests_run++;
      if (bus3.joy_out !== 6'b100011) begin
         tests_failed++;
         $display("FAIL split_pad2_3btn: got out=%b expected %b", bus3.joy_out, 6'b100011);
      end
      split = 1'b1;
   endtask

   task automatic test_reset_mid();
      pad1  = 12'h5A6;
      split = 1'b1;
      mdsel = 1'b1;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         mdsel = ~mdsel;
         tick(3);
      end
      tests_run++;
      if (bus6.phase !== 2'd3 || bus6.joy_out !== 6'b011111) begin
         tests_failed++;
         $display("FAIL reset_mid_pre: got phase=%0d out=%b expected phase=3 out=%b",
                  bus6.phase, bus6.joy_out, 6'b011111);
      end
      reset = 1'b1;
      #2;
      tests_run++;
      if (bus6.joy_out !== 6'h3F || bus6.phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_async: got out=%b phase=%0d expected out=%b phase=0",
                  bus6.joy_out, bus6.phase, 6'h3F);
      end
      tick(2);
      reset = 1'b0;
      tick(4);
      tests_run++;
      if (bus6.phase !== 2'd0 || bus6.joy_out !== 6'b010001) begin
         tests_failed++;
         $display("FAIL reset_mid_release: got phase=%0d out=%b expected phase=0 out=%b",
                  bus6.phase, bus6.joy_out, 6'b010001);
      end
      mdsel = 1'b1;
      tick(3);
      tests_run++;
      if (bus6.phase !== 2'd1 || bus6.joy_out !== 6'b101001) begin
         tests_failed++;
         $display("FAIL reset_mid_rise: got phase=%0d out=%b expected phase=1 out=%b",
                  bus6.phase, bus6.joy_out, 6'b101001);
      end
   endtask

   initial begin
      test_reset();
      test_six_btn();
      test_three_btn();
      test_timeout();
      test_split();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
